pe_conv_sequencer: RTL and testbench
====================================

// Module: pe_conv_sequencer
// PURPOSE
//  Control FSM for the PE convolution array. Per job it takes a kernel/image config,
//  runs a weight-load phase into the PE weight buffers, then streams pixels into the
//  feature buffers via the PE 4:1 mux select, with valid/ready backpressure. It flags
//  each cycle the PE products form a complete KxK window, for the downstream adder tree.
// PARAMETERS
//  DataWidth  8   pixel/weight width (PE datapath width)
//  KMAX       3   largest supported kernel side K
//  DIM_W      8   width of image dimension counters (max W/H = 2**DIM_W-1)
// PORTS
//  CLK        in   1         clock, rising edge
//  RST        in   1         asynchronous, active-low reset
//  cfg_valid  in   1         config offer
//  cfg_ready  out  1         high only in IDLE
//  cfg_k      in   2         kernel side K (1..KMAX)
//  cfg_w      in   DIM_W     image width W
//  cfg_h      in   DIM_W     image height H
//  cfg_err    out  1         1-cycle pulse: config rejected
//  abort      in   1         synchronous job abort
//  wgt_valid  in   1         weight word available
//  wgt_ready  out  1         high only in LOAD_W
//  w_idx      out  clog2(KMAX*KMAX)  index of PE weight buffer being loaded
//  w_load     out  1         = wgt_valid & wgt_ready; PE weight-register enable
//  w_clr      out  1         1-cycle clear of all PE weight buffers (drives RST_W)
//  pe_clr     out  1         1-cycle clear of all PE feature buffers
//  in_valid   in   1         pixel available at array head
//  in_ready   out  1         pixel accepted this cycle when in_valid & in_ready
//  pe_sel     out  2         PE mux select: 0 ZERO, 1 NEW, 2 SHIFT, 3 HOLD
//  out_valid  out  1         PE products P form a complete window
//  out_ready  in   1         downstream accepts window
//  out_row    out  DIM_W     window top-left row (0..H-K)
//  out_col    out  DIM_W     window top-left col (0..W-K)
//  done       out  1         1-cycle pulse: job complete
// BEHAVIOUR
//  Reset (RST=0): state IDLE; counters 0; all outputs 0 except cfg_ready=1.
//  States: IDLE -> CLR -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
//  IDLE: pe_sel=HOLD. On cfg_valid, latch K/W/H. If K==0, K>KMAX, W<K or H<K:
//   pulse cfg_err next cycle and stay IDLE; else go CLR.
//  CLR: one cycle; w_clr=1, pe_clr=1, pe_sel=ZERO. -> LOAD_W.
//  LOAD_W: wgt_ready=1; w_idx counts 0..K*K-1, advancing on each handshake.
//   After handshake at w_idx=K*K-1 -> STREAM. wgt_valid gaps stall without loss.
//  STREAM: in_ready = !(out_valid & !out_ready). On pixel accept: pe_sel=SHIFT
//   (head PE captures stream pixel, others shift). Otherwise pe_sel=HOLD.
//   col wraps W-1->0 and increments row. Last pixel is row=H-1,col=W-1; after it -> DRAIN.
//  Window: a pixel accepted at (r,c) with r>=K-1 and c>=K-1 sets out_valid on the
//   next cycle (1-cycle PE register latency), with out_row=r-K+1, out_col=c-K+1.
//   out_valid holds, with stable row/col, until out_ready. Stalled cycles use pe_sel=HOLD.
//  DRAIN: in_ready=0, pe_sel=HOLD; wait for final window handshake -> DONE.
//  DONE: done=1 one cycle, pe_clr=1 -> IDLE.
//  Simultaneous out handshake and new accept in one cycle is legal; out_valid stays 1
//   and row/col update to the new window.
//  abort (any non-IDLE state): next cycle state IDLE, pe_clr=1, out_valid=0,
//   counters 0, no done pulse. abort in IDLE is ignored. abort wins over cfg_valid.
//  Counters sized to DIM_W; no overflow possible for legal configs.
//  K=1: every accepted pixel yields a window. W=K: one window per row.
// STRUCTURE
//  pe_ctrl_pkg: typedef enum pe_sel_t {SEL_ZERO, SEL_NEW, SEL_SHIFT, SEL_HOLD};
//   typedef enum state_t; KMAX default constant.
//  Sub-module raster_counter (col/row counter with wrap, last and window-valid flags).
//   Instantiated once; FSM and handshakes stay in this module.
// TESTING
//  1 Reset mid-STREAM -> next edge cfg_ready=1; out_valid, in_ready, wgt_ready=0; pe_sel=HOLD.
//  2 K=3,W=5,H=4, all valid/ready high -> 9 weight loads, 20 pixels accepted;
//    6 windows with (row,col) (0,0)..(1,2); first window 1 cycle after pixel 13; done once.
//  3 Same job, out_ready low 4 cycles at first window -> in_ready=0 and pe_sel=HOLD
//    for 4 cycles; window (0,0) held stable; no pixel lost.
//  4 cfg_k=0, then cfg_k=3,W=2 -> cfg_err pulse each time; state stays IDLE; no w_clr.
//  5 abort after 7th pixel -> IDLE next cycle, pe_clr=1, no done; new job then runs clean.
//  6 K=1,W=1,H=1 -> 1 weight, 1 pixel, out_valid (0,0) next cycle, then done.

Source files
------------

// File: rtl/pe_conv_sequencer_pkg.sv
// Shared types and constants for the PE convolution sequencer: mux selects,
// FSM state encoding and default geometry.
package pe_conv_sequencer_pkg;

  localparam int KMAX_DEF  = 3;
  localparam int DIM_W_DEF = 8;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    SEL_ZERO  = 2'd0,
    SEL_NEW   = 2'd1,
    SEL_SHIFT = 2'd2,
    SEL_HOLD  = 2'd3
  } pe_sel_t;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLR    = 3'd1;
  localparam state_t ST_LOAD_W = 3'd2;
  localparam state_t ST_STREAM = 3'd3;
  localparam state_t ST_DRAIN  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // Width of the weight-buffer index; never narrower than one bit.
  function automatic int idx_w(input int kmax);
    return (kmax * kmax > 1) ? $clog2(kmax * kmax) : 1;
  endfunction

endpackage

// File: rtl/pe_conv_sequencer_if.sv
// Handshake and PE-control bundle between the sequencer (slave) and the
// surrounding array/stream logic (master).
interface pe_conv_sequencer_if
  import pe_conv_sequencer_pkg::*;
#(
  parameter int KMAX  = KMAX_DEF,
  parameter int DIM_W = DIM_W_DEF
);
  localparam int WIDX_W = idx_w(KMAX);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_k;
  logic [DIM_W-1:0]  cfg_w;
  logic [DIM_W-1:0]  cfg_h;
  logic              cfg_err;
  logic              abort;
  logic              wgt_valid;
  logic              wgt_ready;
  logic [WIDX_W-1:0] w_idx;
  logic              w_load;
  logic              w_clr;
  logic              pe_clr;
  logic              in_valid;
  logic              in_ready;
  pe_sel_t           pe_sel;
  logic              out_valid;
  logic              out_ready;
  logic [DIM_W-1:0]  out_row;
  logic [DIM_W-1:0]  out_col;
  logic              done;

  modport slave (
    input  cfg_valid, cfg_k, cfg_w, cfg_h, abort, wgt_valid, in_valid, out_ready,
    output cfg_ready, cfg_err, wgt_ready, w_idx, w_load, w_clr, pe_clr,
           in_ready, pe_sel, out_valid, out_row, out_col, done
  );

  modport master (
    output cfg_valid, cfg_k, cfg_w, cfg_h, abort, wgt_valid, in_valid, out_ready,
    input  cfg_ready, cfg_err, wgt_ready, w_idx, w_load, w_clr, pe_clr,
           in_ready, pe_sel, out_valid, out_row, out_col, done
  );

endinterface

// File: rtl/pe_conv_sequencer_raster_counter.sv
// Raster position of the next pixel to enter the array, with end-of-image and
// complete-window flags for that position.
module raster_counter #(
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIM_W-1:0] km1,
  input  logic [DIM_W-1:0] w,
  input  logic [DIM_W-1:0] h,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic             last,
  output logic             win
);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col == w - ONE) begin
        col <= '0;
        row <= row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end

  assign last = (row == h - ONE) && (col == w - ONE);
  assign win  = (row >= km1) && (col >= km1);

endmodule

// File: rtl/pe_conv_sequencer.sv
// Job sequencer for the PE convolution array: config check, weight load,
// pixel streaming with backpressure and complete-window flagging.
module pe_conv_sequencer
  import pe_conv_sequencer_pkg::*;
#(
  parameter int KMAX  = KMAX_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  pe_conv_sequencer_if.slave bus
);
  localparam int WIDX_W = idx_w(KMAX);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_t            state, state_nx;
  logic [1:0]        k_q;
  logic [DIM_W-1:0]  w_q, h_q;
  logic [WIDX_W-1:0] w_idx_q;
  logic              err_q, abort_clr_q;
  logic              vld_p1;
  logic [DIM_W-1:0]  row_p1, col_p1;

  logic [DIM_W-1:0]  cfg_k_ext, km1, col, row;
  logic [3:0]        kk;
  logic [WIDX_W-1:0] kk_m1;
  logic              cfg_bad, abort_any, wgt_hs, in_rdy, accept, out_hs;
  logic              last, win, raster_clr;
  pe_sel_t           pe_sel_c;

  assign cfg_k_ext = DIM_W'(bus.cfg_k);
  assign cfg_bad   = (bus.cfg_k == 2'd0) || (int'(bus.cfg_k) > KMAX) ||
                     (bus.cfg_w < cfg_k_ext) || (bus.cfg_h < cfg_k_ext);

  assign km1   = DIM_W'(k_q) - ONE;
  assign kk    = {2'b00, k_q} * {2'b00, k_q};
  assign kk_m1 = WIDX_W'(kk - 4'd1);

  assign abort_any = bus.abort && (state != ST_IDLE);
  assign wgt_hs    = bus.wgt_valid && (state == ST_LOAD_W);
  // A window waiting on the consumer blocks the next shift so P stays intact.
  assign in_rdy    = (state == ST_STREAM) && !(vld_p1 && !bus.out_ready);
  assign accept    = bus.in_valid && in_rdy;
  assign out_hs    = vld_p1 && bus.out_ready;
  assign raster_clr = (state == ST_CLR) || abort_any;

  raster_counter #(.DIM_W(DIM_W)) u_raster (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (raster_clr),
    .adv  (accept),
    .km1  (km1),
    .w    (w_q),
    .h    (h_q),
    .col  (col),
    .row  (row),
    .last (last),
    .win  (win)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.cfg_valid && !cfg_bad) state_nx = ST_CLR;
      ST_CLR:    state_nx = ST_LOAD_W;
      ST_LOAD_W: if (wgt_hs && (w_idx_q == kk_m1)) state_nx = ST_STREAM;
      ST_STREAM: if (accept && last) state_nx = ST_DRAIN;
      ST_DRAIN:  if (out_hs) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (abort_any) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      k_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      err_q       <= 1'b0;
      abort_clr_q <= 1'b0;
      w_idx_q     <= '0;
    end else begin
      state       <= state_nx;
      err_q       <= (state == ST_IDLE) && bus.cfg_valid && cfg_bad;
      abort_clr_q <= abort_any;
      if ((state == ST_IDLE) && bus.cfg_valid) begin
        k_q <= bus.cfg_k;
        w_q <= bus.cfg_w;
        h_q <= bus.cfg_h;
      end
      if (abort_any) w_idx_q <= '0;
      else if (wgt_hs) w_idx_q <= (w_idx_q == kk_m1) ? '0 : w_idx_q + WIDX_W'(1);
    end
  end

  // p1: PE products settle one cycle after the completing pixel is shifted in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      row_p1 <= '0;
      col_p1 <= '0;
    end else if (abort_any) begin
      vld_p1 <= 1'b0;
      row_p1 <= '0;
      col_p1 <= '0;
    end else if (accept && win) begin
      vld_p1 <= 1'b1;
      row_p1 <= row - km1;
      col_p1 <= col - km1;
    end else if (out_hs) begin
      vld_p1 <= 1'b0;
    end
  end

  always_comb begin
    pe_sel_c = SEL_HOLD;
    if (state == ST_CLR) pe_sel_c = SEL_ZERO;
    else if (accept)     pe_sel_c = SEL_SHIFT;
  end

  assign bus.cfg_ready = (state == ST_IDLE);
  assign bus.cfg_err   = err_q;
  assign bus.wgt_ready = (state == ST_LOAD_W);
  assign bus.w_idx     = w_idx_q;
  assign bus.w_load    = wgt_hs;
  assign bus.w_clr     = (state == ST_CLR);
  assign bus.pe_clr    = (state == ST_CLR) || (state == ST_DONE) || abort_clr_q;
  assign bus.in_ready  = in_rdy;
  assign bus.pe_sel    = pe_sel_c;
  assign bus.out_valid = vld_p1;
  assign bus.out_row   = row_p1;
  assign bus.out_col   = col_p1;
  assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Directed bench for pe_conv_sequencer: reset, full jobs, backpressure,
// config rejection, abort and the 1x1 corner case.
module tb_pe_conv_sequencer;
  import pe_conv_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_conv_sequencer_if #(.KMAX(3), .DIM_W(8)) bus ();

  pe_conv_sequencer #(.KMAX(3), .DIM_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Event log sampled on the falling edge, mid-cycle.
  int cyc = 0, px_cnt = 0, wl_cnt = 0, win_cnt = 0, done_cnt = 0;
  int wclr_cnt = 0, err_cnt = 0, rise_cnt = 0;
  int px_cyc [256];
  int wl_idx [64];
  int win_row [64];
  int win_col [64];
  int rise_cyc [64];
  logic ov_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready) begin
      px_cyc[px_cnt % 256] <= cyc;
      px_cnt <= px_cnt + 1;
    end
    if (bus.w_load) begin
      wl_idx[wl_cnt % 64] <= int'(bus.w_idx);
      wl_cnt <= wl_cnt + 1;
    end
    if (bus.out_valid && bus.out_ready) begin
      win_row[win_cnt % 64] <= int'(bus.out_row);
      win_col[win_cnt % 64] <= int'(bus.out_col);
      win_cnt <= win_cnt + 1;
    end
    if (bus.out_valid && !ov_prev) begin
      rise_cyc[rise_cnt % 64] <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    if (bus.done)    done_cnt <= done_cnt + 1;
    if (bus.w_clr)   wclr_cnt <= wclr_cnt + 1;
    if (bus.cfg_err) err_cnt  <= err_cnt + 1;
    ov_prev <= bus.out_valid;
  end

  int b_px, b_wl, b_win, b_done, b_wclr, b_err, b_rise;

  task automatic snap();
    b_px = px_cnt; b_wl = wl_cnt; b_win = win_cnt; b_done = done_cnt;
    b_wclr = wclr_cnt; b_err = err_cnt; b_rise = rise_cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [1:0] k, input logic [7:0] w, input logic [7:0] h);
    tick();
    bus.cfg_valid = 1'b1;
    bus.cfg_k = k;
    bus.cfg_w = w;
    bus.cfg_h = h;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > b_done) break;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_px(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (px_cnt - b_px >= n) break;
    end
  endtask

  // K=3, W=5, H=4: windows at rows 0..1, cols 0..2 in raster order.
  task automatic check_k3_job(input string tag);
    int exp_row [6] = '{0, 0, 0, 1, 1, 1};
    int exp_col [6] = '{0, 1, 2, 0, 1, 2};
    chk({tag, " wloads"}, wl_cnt - b_wl, 9);
    for (int i = 0; i < 9; i++) chk({tag, " widx"}, wl_idx[(b_wl + i) % 64], i);
    chk({tag, " pixels"}, px_cnt - b_px, 20);
    chk({tag, " windows"}, win_cnt - b_win, 6);
    for (int i = 0; i < 6; i++) begin
      chk({tag, " win_row"}, win_row[(b_win + i) % 64], exp_row[i]);
      chk({tag, " win_col"}, win_col[(b_win + i) % 64], exp_col[i]);
    end
    chk({tag, " done"}, done_cnt - b_done, 1);
    chk({tag, " first_win_lat"}, rise_cyc[b_rise % 64] - px_cyc[(b_px + 12) % 256], 1);
    chk({tag, " wclr"}, wclr_cnt - b_wclr, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_k = '0; bus.cfg_w = '0; bus.cfg_h = '0;
    bus.abort = 1'b0; bus.wgt_valid = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst cfg_ready", bus.cfg_ready, 1);
    chk("rst cfg_err", bus.cfg_err, 0);
    chk("rst wgt_ready", bus.wgt_ready, 0);
    chk("rst w_load", bus.w_load, 0);
    chk("rst w_clr", bus.w_clr, 0);
    chk("rst pe_clr", bus.pe_clr, 0);
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst pe_sel", bus.pe_sel, SEL_HOLD);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_row", bus.out_row, 0);
    chk("rst out_col", bus.out_col, 0);
    chk("rst done", bus.done, 0);
    chk("rst w_idx", bus.w_idx, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    bus.wgt_valid = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;

    // Full K=3 job, no backpressure
    snap();
    run_job(2'd3, 8'd5, 8'd4);
    wait_done(300);
    repeat (3) tick();
    check_k3_job("job");

    // Same job with the consumer stalling 4 cycles on the first window
    snap();
    run_job(2'd3, 8'd5, 8'd4);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) break;
    end
    bus.out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #2;
      end else begin
        #1;
      end
      chk("stall in_ready", bus.in_ready, 0);
      chk("stall pe_sel", bus.pe_sel, SEL_HOLD);
      chk("stall out_valid", bus.out_valid, 1);
      chk("stall out_row", bus.out_row, 0);
      chk("stall out_col", bus.out_col, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done(300);
    repeat (3) tick();
    check_k3_job("stall");

    // Rejected configs: K=0, then W<K
    snap();
    run_job(2'd0, 8'd5, 8'd4);
    chk("k0 cfg_err", bus.cfg_err, 1);
    chk("k0 cfg_ready", bus.cfg_ready, 1);
    tick();
    chk("k0 err_pulse_end", bus.cfg_err, 0);
    chk("k0 idle", bus.cfg_ready, 1);
    run_job(2'd3, 8'd2, 8'd4);
    chk("w_lt_k cfg_err", bus.cfg_err, 1);
    chk("w_lt_k wgt_ready", bus.wgt_ready, 0);
    tick();
    chk("w_lt_k err_pulse_end", bus.cfg_err, 0);
    chk("w_lt_k idle", bus.cfg_ready, 1);
    tick();
    chk("bad_cfg err_count", err_cnt - b_err, 2);
    chk("bad_cfg no_wclr", wclr_cnt - b_wclr, 0);

    // Abort after the 7th pixel, then a clean job
    snap();
    run_job(2'd3, 8'd5, 8'd4);
    wait_px(7, 200);
    bus.abort = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    chk("abort cfg_ready", bus.cfg_ready, 1);
    chk("abort pe_clr", bus.pe_clr, 1);
    chk("abort out_valid", bus.out_valid, 0);
    chk("abort in_ready", bus.in_ready, 0);
    chk("abort done", bus.done, 0);
    chk("abort pixels", px_cnt - b_px, 7);
    bus.abort = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    chk("abort pe_clr_end", bus.pe_clr, 0);
    repeat (4) tick();
    chk("abort no_done", done_cnt - b_done, 0);
    snap();
    run_job(2'd3, 8'd5, 8'd4);
    wait_done(300);
    repeat (3) tick();
    check_k3_job("post_abort");

    // K=1, W=1, H=1
    snap();
    run_job(2'd1, 8'd1, 8'd1);
    wait_done(100);
    repeat (3) tick();
    chk("k1 wloads", wl_cnt - b_wl, 1);
    chk("k1 pixels", px_cnt - b_px, 1);
    chk("k1 windows", win_cnt - b_win, 1);
    chk("k1 win_row", win_row[b_win % 64], 0);
    chk("k1 win_col", win_col[b_win % 64], 0);
    chk("k1 latency", rise_cyc[b_rise % 64] - px_cyc[b_px % 256], 1);
    chk("k1 done", done_cnt - b_done, 1);

    // Asynchronous reset in the middle of streaming
    snap();
    run_job(2'd3, 8'd5, 8'd4);
    wait_px(3, 200);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst cfg_ready", bus.cfg_ready, 1);
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst in_ready", bus.in_ready, 0);
    chk("midrst wgt_ready", bus.wgt_ready, 0);
    chk("midrst pe_sel", bus.pe_sel, SEL_HOLD);
    chk("midrst done", bus.done, 0);
    #3 rst_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
